// File: rtl/spi_protocol_burst.sv
// SPI burst protocol engine: decodes a command word, then streams len+1 register
// writes, or len+1 read-ahead reads, per chip-select frame.
module spi_protocol_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_fe_in,
    input  logic              ss_pos_edge,
    input  logic              ss_neg_edge,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [DATA_W-1:0] data_fe_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              we,
    output logic              re,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_re;
    logic              r_err;
    logic              r_rdy;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] r_data_fe_out;
    logic              w_busy;

    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_rnw;
    logic [LEN_W-1:0]  w_cmd_len;
    logic              w_cmd;
    logic              w_word;
    logic              w_abort;
    logic              w_last;

    assign w_cmd_addr = data_fe_in[ADDR_W-1:0];
    assign w_cmd_rnw  = data_fe_in[ADDR_W];
    assign w_cmd_len  = data_fe_in[ADDR_W+LEN_W:ADDR_W+1];

    // Frame end outranks a word boundary once a burst is in progress.
    assign w_cmd   = (r_state == S_IDLE) && ss_pos_edge;
    assign w_abort = (r_state != S_IDLE) && ss_neg_edge;
    assign w_word  = (r_state != S_IDLE) && ss_pos_edge && !ss_neg_edge;
    assign w_last  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd) begin
                    w_next_state = w_cmd_rnw ? S_READ : S_WRITE;
                end
            end
            S_WRITE, S_READ: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_word && w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_re          <= 1'b0;
            r_err         <= 1'b0;
            r_rdy         <= 1'b0;
            r_data_out    <= '0;
            r_data_fe_out <= '0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            // Post-write increment happens even if the frame was aborted meanwhile.
            if (r_we) begin
                r_addr <= r_addr + ADDR_ONE;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        r_addr <= w_cmd_addr;
                        r_cnt  <= w_cmd_len;
                        r_err  <= 1'b0;
                        r_rdy  <= 1'b0;
                        r_re   <= w_cmd_rnw;
                    end
                end
                S_WRITE: begin
                    if (w_word) begin
                        r_data_out <= data_fe_in;
                        r_we       <= 1'b1;
                        if (!w_last) begin
                            r_cnt <= r_cnt - LEN_ONE;
                        end
                    end
                end
                S_READ: begin
                    if (data_in_valid) begin
                        r_data_fe_out <= data_in;
                        r_rdy         <= 1'b1;
                    end
                    // A word boundary before the read data arrived is an underrun.
                    if (w_word) begin
                        r_rdy <= 1'b0;
                        if (!r_rdy) begin
                            r_err <= 1'b1;
                        end
                        if (!w_last) begin
                            r_cnt  <= r_cnt - LEN_ONE;
                            r_addr <= r_addr + ADDR_ONE;
                            r_re   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_fe_out = r_data_fe_out;
    assign data_out    = r_data_out;
    assign address     = r_addr;
    assign we          = r_we;
    assign re          = r_re;
    assign busy        = w_busy;
    assign err         = r_err;

endmodule

// File: tb/tb_spi_protocol_burst.sv
// Scoreboard bench for spi_protocol_burst: stimulus pushes expected register
// accesses; a monitor pops and compares them as we/re/data_fe_out appear.
`timescale 1ns/1ps
module tb_spi_protocol_burst;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;
    localparam int WR_W   = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_fe_in = '0;
    logic              ss_pos_edge = 1'b0;
    logic              ss_neg_edge = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_valid = 1'b0;
    logic [DATA_W-1:0] data_fe_out;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address;
    logic              we;
    logic              re;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    spi_protocol_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .data_fe_in(data_fe_in), .ss_pos_edge(ss_pos_edge),
        .ss_neg_edge(ss_neg_edge), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_fe_out(data_fe_out), .data_out(data_out), .address(address),
        .we(we), .re(re), .busy(busy), .err(err)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [WR_W-1:0]   q_wr[$];
    logic [ADDR_W-1:0] q_re[$];
    logic [DATA_W-1:0] q_fe[$];
    int   rsp_lat = 2;
    int   rsp_cnt = 0;
    logic chk_fe  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: unexpected event, value 0x%0h (t=%0t)", name, act, $time);
    endtask

    // Register-file responder: answers each re with random data after rsp_lat cycles.
    always @(posedge clk) begin
        #2;
        data_in_valid = 1'b0;
        if (rst) begin
            rsp_cnt = 0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    data_in       = DATA_W'($urandom);
                    data_in_valid = 1'b1;
                    q_fe.push_back(data_in);
                end
            end
            if (re === 1'b1) rsp_cnt = rsp_lat;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        logic [WR_W-1:0] e;
        if (chk_fe) begin
            if (q_fe.size() == 0) fail("fe_load", 64'(data_fe_out));
            else chk("data_fe_out", 64'(data_fe_out), 64'(q_fe.pop_front()));
        end
        chk_fe = (data_in_valid === 1'b1);
        if (we === 1'b1) begin
            if (q_wr.size() == 0) begin
                fail("we_pulse", 64'(address));
            end else begin
                e = q_wr.pop_front();
                chk("we_addr", 64'(address), 64'(e[WR_W-1:DATA_W]));
                chk("we_data", 64'(data_out), 64'(e[DATA_W-1:0]));
            end
        end
        if (re === 1'b1) begin
            if (q_re.size() == 0) fail("re_pulse", 64'(address));
            else chk("re_addr", 64'(address), 64'(q_re.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_word(input logic [DATA_W-1:0] w, input int gap);
        data_fe_in  = w;
        ss_pos_edge = 1'b1;
        tick();
        ss_pos_edge = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic end_frame();
        ss_neg_edge = 1'b1;
        tick();
        ss_neg_edge = 1'b0;
        tick();
    endtask

    function automatic logic [DATA_W-1:0] mk_cmd(input logic [ADDR_W-1:0] a, input logic rnw,
                                                 input logic [LEN_W-1:0] len);
        logic [DATA_W-1:0] c;
        c = DATA_W'($urandom);
        c[ADDR_W-1:0] = a;
        c[ADDR_W] = rnw;
        c[ADDR_W+LEN_W:ADDR_W+1] = len;
        return c;
    endfunction

    task automatic write_burst(input logic [ADDR_W-1:0] base, input int len, input int gap);
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] a;
        pulse_word(mk_cmd(base, 1'b0, LEN_W'(len)), gap);
        for (int i = 0; i <= len; i++) begin
            w = DATA_W'($urandom);
            a = base + ADDR_W'(i);
            q_wr.push_back({a, w});
            pulse_word(w, gap);
        end
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] base, input int len, input int gap);
        q_re.push_back(base);
        pulse_word(mk_cmd(base, 1'b1, LEN_W'(len)), gap);
        for (int i = 0; i <= len; i++) begin
            if (i < len) q_re.push_back(base + ADDR_W'(i + 1));
            pulse_word(DATA_W'($urandom), gap);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_re"}, 64'(re), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_addr"}, 64'(address), 64'd0);
        chk({tag, "_data_out"}, 64'(data_out), 64'd0);
        chk({tag, "_fe_out"}, 64'(data_fe_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] w;
        int len;
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Write burst 0x10, three words, then a word ignored in DONE.
        write_burst(8'h10, 2, 3);
        chk("wr_busy_done", 64'(busy), 64'd1);
        chk("wr_addr_after", 64'(address), 64'h13);
        pulse_word(DATA_W'($urandom), 3);
        chk("done_addr_hold", 64'(address), 64'h13);
        end_frame();
        chk("wr_idle", 64'(busy), 64'd0);

        // Read burst 0x20, two words, data two cycles after each re.
        rsp_lat = 2;
        read_burst(8'h20, 1, 8);
        chk("rd_err", 64'(err), 64'd0);
        chk("rd_busy_done", 64'(busy), 64'd1);
        end_frame();
        chk("rd_idle", 64'(busy), 64'd0);

        // Address wrap.
        write_burst(8'hFF, 1, 3);
        end_frame();

        // Underrun: word boundary before read data arrives.
        base = ADDR_W'($urandom);
        q_re.push_back(base);
        pulse_word(mk_cmd(base, 1'b1, LEN_W'(1)), 0);
        q_re.push_back(base + ADDR_W'(1));
        pulse_word(DATA_W'($urandom), 8);
        chk("underrun_err", 64'(err), 64'd1);
        pulse_word(DATA_W'($urandom), 4);
        end_frame();
        chk("underrun_sticky", 64'(err), 64'd1);
        pulse_word(mk_cmd(ADDR_W'($urandom), 1'b0, LEN_W'(0)), 3);
        chk("err_cleared", 64'(err), 64'd0);
        w = DATA_W'($urandom);
        q_wr.push_back({address, w});
        pulse_word(w, 3);
        end_frame();

        // Abort on the second data word of a len=3 write.
        base = ADDR_W'($urandom);
        write_burst_abort: begin
            pulse_word(mk_cmd(base, 1'b0, LEN_W'(3)), 3);
            w = DATA_W'($urandom);
            q_wr.push_back({base, w});
            pulse_word(w, 3);
            data_fe_in  = DATA_W'($urandom);
            ss_pos_edge = 1'b1;
            ss_neg_edge = 1'b1;
            tick();
            ss_pos_edge = 1'b0;
            ss_neg_edge = 1'b0;
            chk("abort_idle", 64'(busy), 64'd0);
            repeat (5) tick();
        end

        // Reset mid read burst, together with a word boundary.
        base = ADDR_W'($urandom);
        q_re.push_back(base);
        pulse_word(mk_cmd(base, 1'b1, LEN_W'(3)), 8);
        q_re.push_back(base + ADDR_W'(1));
        pulse_word(DATA_W'($urandom), 8);
        data_fe_in  = DATA_W'($urandom);
        ss_pos_edge = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ss_pos_edge = 1'b0;
        chk_reset_vals("midrst");
        repeat (10) tick();
        chk("midrst_idle", 64'(busy), 64'd0);

        // Randomized bursts.
        for (int n = 0; n < 24; n++) begin
            base = ADDR_W'($urandom);
            len  = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin
                rsp_lat = $urandom_range(1, 3);
                read_burst(base, len, 8);
            end else begin
                write_burst(base, len, $urandom_range(1, 4));
            end
            chk("rand_busy_done", 64'(busy), 64'd1);
            chk("rand_err", 64'(err), 64'd0);
            end_frame();
            chk("rand_idle", 64'(busy), 64'd0);
        end

        repeat (6) tick();
        chk("wr_queue_left", 64'(q_wr.size()), 64'd0);
        chk("re_queue_left", 64'(q_re.size()), 64'd0);
        chk("fe_queue_left", 64'(q_fe.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
